bob_uart_tx: RTL and testbench
==============================

Name: bob_uart_tx

Overview:
UART transmit serializer that sits directly downstream of Bob's reply path. It consumes the 9-bit reply words presented on uart_tx_data/uart_tx_send and drives them onto the serial line tx. It exposes uart_tx_ready so that Bob's reply sender starts a transfer only when the serializer is idle. Frame format is 1 start bit (0), 9 data bits LSB first, an optional even-parity bit, and 1 stop bit (1).

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (baud divider); legal range >= 2
PARITY_EN, 0, 1 = insert even-parity bit between data bit 8 and the stop bit; 0 = no parity bit

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
uart_tx_data  input  9  reply word {plane_id[3:0], msg_type[2:0], msg_action[1:0]}; sampled only on acceptance
uart_tx_send  input  1  transfer request, normally a 1-cycle pulse
uart_tx_ready  output  1  high when idle and able to accept a word
tx  output  1  serial line, idle high, registered
tx_done  output  1  1-cycle pulse when the stop bit completes

Behaviour:
- Reset: asynchronous. Values: tx=1, uart_tx_ready=1, tx_done=0, state=IDLE, all counters 0. Reset in the middle of a frame aborts it immediately; tx goes high with no glitch low after reset.
- Acceptance: on a clock edge where uart_tx_send=1 and uart_tx_ready=1:
  - uart_tx_data is latched into a shift register.
  - Parity is computed (XOR of the 9 bits).
  - tx<=0, uart_tx_ready<=0, state<=START, baud counter<=0.
  - uart_tx_ready is therefore low from the cycle after acceptance.
- Ignored sends: uart_tx_send while uart_tx_ready=0 is ignored; the latched data is not disturbed. Changes to uart_tx_data after acceptance have no effect.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - Each non-IDLE state holds tx constant for exactly CLKS_PER_BIT cycles.
  - Baud counter runs 0..CLKS_PER_BIT-1; the bit boundary is at CLKS_PER_BIT-1.
- START: tx=0. At the boundary: tx<=data[0], bit index<=0, state<=DATA.
- DATA: 4-bit bit index 0..8.
  - At a boundary with index<8: index++ and tx<=next bit (shift right, LSB first).
  - At the boundary with index==8: tx<=parity and state<=PARITY if PARITY_EN, otherwise tx<=1 and state<=STOP.
- PARITY: tx = ^data (even parity: total ones over data plus parity is even). At the boundary: tx<=1, state<=STOP.
- STOP: tx=1. At the boundary: state<=IDLE, uart_tx_ready<=1, tx_done<=1 for one cycle.
- Frame length: (11 + PARITY_EN) * CLKS_PER_BIT cycles, from the acceptance edge to the edge where uart_tx_ready rises.
- Back-to-back: uart_tx_send may be asserted in the first cycle uart_tx_ready is high again; the next start bit then follows the stop bit with no extra idle cycle.
- tx_done=0 at all other times. uart_tx_ready is never high while a frame is in flight.
- Counter widths: baud counter $clog2(CLKS_PER_BIT) bits, wrapping to 0 at each boundary. The bit index never exceeds 8.

Test Plan:
- Reset then idle, no send for 100 cycles -> tx=1, uart_tx_ready=1, tx_done=0 throughout.
- CLKS_PER_BIT=4, PARITY_EN=0, send 9'h1A5 ->
  - Line sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1,1, 1.
  - uart_tx_ready low for 44 cycles; tx_done pulses once, in the cycle uart_tx_ready rises.
- CLKS_PER_BIT=4, PARITY_EN=1, send 9'h1A5 -> parity bit 1 after data bit 8; frame length 48 cycles. Send 9'h003 -> parity bit 0.
- Send 9'h0F0, then pulse uart_tx_send with 9'h1FF at cycle 10 of the frame -> second word ignored; line carries only 9'h0F0.
- Back-to-back: send 9'h155, then send 9'h0AA in the cycle ready returns -> stop bit of the first frame is followed immediately by the start bit of the second; both decode correctly.
- Assert reset_n=0 mid-DATA of 9'h000 -> tx=1 and uart_tx_ready=1 immediately. After release, send 9'h1C3 -> clean full frame.

Source files
------------

// File: rtl/bob_uart_tx_if.sv
// Reply-word handshake between Bob's reply sender (master) and the UART serializer (slave).
interface bob_uart_tx_if;
  logic [8:0] uart_tx_data;
  logic       uart_tx_send;
  logic       uart_tx_ready;

  modport master (output uart_tx_data, output uart_tx_send, input uart_tx_ready);
  modport slave  (input uart_tx_data, input uart_tx_send, output uart_tx_ready);
endinterface

// File: rtl/bob_uart_tx.sv
// UART transmit serializer: 1 start, 9 data bits LSB first, optional even parity, 1 stop.
module bob_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  bob_uart_tx_if.slave  host,
  output logic          tx,
  output logic          tx_done
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic                par_q, par_n;
  logic                tx_n;
  logic                ready_q, ready_n;
  logic                done_n;
  logic                boundary;

  assign host.uart_tx_ready = ready_q;
  assign boundary           = (cnt_q == LAST_CNT);

  // State and registered outputs; reset drops the line straight back to idle-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx      <= tx_n;
      ready_q <= ready_n;
      tx_done <= done_n;
    end
  end

  // Next-state and next-output logic; tx is set one bit ahead at each boundary.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    par_n   = par_q;
    tx_n    = tx;
    ready_n = ready_q;
    done_n  = 1'b0;

    if (state_q != IDLE) begin
      cnt_n = boundary ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (host.uart_tx_send && ready_q) begin
          shift_n = host.uart_tx_data;
          par_n   = ^host.uart_tx_data;
          tx_n    = 1'b0;
          ready_n = 1'b0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (boundary) begin
          tx_n    = shift_q[0];
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (boundary) begin
          if (idx_q < LAST_IDX) begin
            idx_n   = idx_q + IDX_W'(1);
            shift_n = {1'b0, shift_q[DATA_W-1:1]};
            tx_n    = shift_q[1];
          end else if (PARITY_EN) begin
            tx_n    = par_q;
            state_n = PARITY;
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (boundary) begin
          state_n = IDLE;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bob_uart_tx.sv
// Directed bench for bob_uart_tx: two instances (with/without parity) and a serial-line scoreboard.
module tb_bob_uart_tx;

  localparam int CPB = 4;

  logic clock;
  logic reset_n;
  logic tx0, tx1, done0, done1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] exp0[$];
  logic [8:0] exp1[$];

  bob_uart_tx_if bus0 ();
  bob_uart_tx_if bus1 ();

  bob_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .host(bus0), .tx(tx0), .tx_done(done0));

  bob_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .host(bus1), .tx(tx1), .tx_done(done1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic txs(input int u);
    return (u == 0) ? tx0 : tx1;
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? bus0.uart_tx_ready : bus1.uart_tx_ready;
  endfunction

  function automatic logic dn(input int u);
    return (u == 0) ? done0 : done1;
  endfunction

  task automatic drive(input int u, input logic s, input logic [8:0] d);
    if (u == 0) begin bus0.uart_tx_send = s; bus0.uart_tx_data = d; end
    else        begin bus1.uart_tx_send = s; bus1.uart_tx_data = d; end
  endtask

  // Line monitor: samples every cycle of a frame, decodes it and checks against the queue.
  task automatic mon(input int u, input int nbits);
    logic [11:0]    bits;
    logic [CPB-1:0] smp;
    logic           aborted, uneven;
    logic [8:0]     expw;
    forever begin
      @(negedge clock);
      if (reset_n && txs(u) == 1'b0) begin
        aborted = 1'b0;
        uneven  = 1'b0;
        bits    = '0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clock);
            if (!reset_n) aborted = 1'b1;
            smp[s] = txs(u);
          end
          if (smp != '0 && smp != '1) uneven = 1'b1;
          bits[b] = smp[0];
        end
        if (!aborted) begin
          chk($sformatf("u%0d bit_width", u), 32'(uneven), 32'd0);
          chk($sformatf("u%0d start_bit", u), 32'(bits[0]), 32'd0);
          chk($sformatf("u%0d stop_bit", u), 32'(bits[nbits-1]), 32'd1);
          if ((u == 0 ? exp0.size() : exp1.size()) == 0) begin
            chk($sformatf("u%0d unexpected_frame", u), 32'(bits[9:1]), 32'h200);
          end else begin
            expw = (u == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("u%0d word", u), 32'(bits[9:1]), 32'(expw));
            if (nbits == 12) chk($sformatf("u%0d parity", u), 32'(bits[10]), 32'(^expw));
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0, 11);
      mon(1, 12);
    join_none
  end

  task automatic start_word(input int u, input logic [8:0] d);
    chk($sformatf("u%0d ready_before_send", u), 32'(rdy(u)), 32'd1);
    drive(u, 1'b1, d);
    if (u == 0) exp0.push_back(d); else exp1.push_back(d);
    @(negedge clock);
    drive(u, 1'b0, 9'($urandom));
  endtask

  // Counts busy cycles until ready returns; optionally pulses a stray send mid-frame.
  task automatic frame(input int u, input int len, input int inject);
    int   low = 0;
    logic early_done = 1'b0;
    while (rdy(u) == 1'b0 && low < len + 20) begin
      low++;
      if (dn(u)) early_done = 1'b1;
      if (low == inject) drive(u, 1'b1, 9'h1FF);
      else               drive(u, 1'b0, 9'($urandom));
      @(negedge clock);
    end
    drive(u, 1'b0, 9'($urandom));
    chk($sformatf("u%0d busy_cycles", u), 32'(low), 32'(len));
    chk($sformatf("u%0d done_early", u), 32'(early_done), 32'd0);
    chk($sformatf("u%0d done_at_ready", u), 32'(dn(u)), 32'd1);
  endtask

  task automatic gap(input int u);
    @(negedge clock);
    chk($sformatf("u%0d done_single", u), 32'(dn(u)), 32'd0);
    chk($sformatf("u%0d tx_idle", u), 32'(txs(u)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    repeat (3) @(negedge clock);
    chk("reset tx0", 32'(tx0), 32'd1);
    chk("reset ready0", 32'(bus0.uart_tx_ready), 32'd1);
    chk("reset done0", 32'(done0), 32'd0);
    chk("reset tx1", 32'(tx1), 32'd1);
    chk("reset ready1", 32'(bus1.uart_tx_ready), 32'd1);
    chk("reset done1", 32'(done1), 32'd0);
    reset_n = 1'b1;

    // Idle: no sends for 100 cycles
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("idle u%0d tx", u), 32'(txs(u)), 32'd1);
        chk($sformatf("idle u%0d ready", u), 32'(rdy(u)), 32'd1);
        chk($sformatf("idle u%0d done", u), 32'(dn(u)), 32'd0);
      end
    end

    // Plain frame, no parity
    start_word(0, 9'h1A5);
    frame(0, 11 * CPB, -1);
    gap(0);

    // Parity frames: 1A5 has odd weight, 003 even
    start_word(1, 9'h1A5);
    frame(1, 12 * CPB, -1);
    gap(1);
    start_word(1, 9'h003);
    frame(1, 12 * CPB, -1);
    gap(1);

    // Send while busy is ignored
    start_word(0, 9'h0F0);
    frame(0, 11 * CPB, 10);
    gap(0);

    // Back-to-back in the first ready cycle
    start_word(0, 9'h155);
    frame(0, 11 * CPB, -1);
    start_word(0, 9'h0AA);
    frame(0, 11 * CPB, -1);
    gap(0);

    // Reset in the middle of the data bits
    start_word(0, 9'h000);
    repeat (12) @(negedge clock);
    chk("midframe busy", 32'(bus0.uart_tx_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort tx", 32'(tx0), 32'd1);
    chk("abort ready", 32'(bus0.uart_tx_ready), 32'd1);
    chk("abort done", 32'(done0), 32'd0);
    exp0.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("post_reset tx", 32'(tx0), 32'd1);
      chk("post_reset ready", 32'(bus0.uart_tx_ready), 32'd1);
    end
    start_word(0, 9'h1C3);
    frame(0, 11 * CPB, -1);
    gap(0);

    repeat (10) @(negedge clock);
    chk("scoreboard0 drained", 32'(exp0.size()), 32'd0);
    chk("scoreboard1 drained", 32'(exp1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
